ram_hex_dumper: RTL and testbench

- Hardware engine that walks CPU RAM after halt and streams its non-zero words as ASCII Intel HEX records on a byte stream. Typical sink is a UART TX.
- Sits directly downstream of the RAM debug port. Drives override_ctrl, iaddr and iren; consumes iload and iwait.
- Replaces the simulation-only dump task so silicon and FPGA builds can emit the same dump image.

---
 rtl/ram_hex_dumper_if.sv | 26 ++
 rtl/ram_hex_dumper.sv | 221 ++++++++++++++++++++++
 tb/tb_ram_hex_dumper.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_hex_dumper_if.sv
// Control, RAM debug-port and character-stream signals of ram_hex_dumper.
interface ram_hex_dumper_if;
  logic        start;
  logic        override_ctrl;
  logic [31:0] iaddr;
  logic        iren;
  logic [31:0] iload;
  logic        iwait;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  // Dumper side
  modport master (
    input  start, iload, iwait, tx_ready,
    output override_ctrl, iaddr, iren, tx_data, tx_valid, busy, done
  );

  // RAM / sink / controller side
  modport slave (
    output start, iload, iwait, tx_ready,
    input  override_ctrl, iaddr, iren, tx_data, tx_valid, busy, done
  );
endinterface

// File: rtl/ram_hex_dumper.sv
// Walks RAM through the debug port and streams non-zero words as Intel HEX
// data records followed by an EOF record.
// Optional build macro RAMDUMP_CRLF_EN: lines end in "\r\n" instead of "\n".
module ram_hex_dumper #(
  parameter int unsigned WORDS  = 16384,
  parameter int unsigned ADDR_W = 16
) (
  input logic              clk,
  input logic              rst,
  ram_hex_dumper_if.master bus
);

  localparam int unsigned IDX_W  = $clog2(WORDS) + 1;
  localparam int unsigned CHAR_W = 5;
  localparam int unsigned SLOTS  = 32;
`ifdef RAMDUMP_CRLF_EN
  localparam int unsigned REC_LEN = 21;
  localparam int unsigned EOF_LEN = 13;
`else
  localparam int unsigned REC_LEN = 20;
  localparam int unsigned EOF_LEN = 12;
`endif

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_CHECK    = 3'd2,
    S_EMIT_REC = 3'd3,
    S_NEXT     = 3'd4,
    S_EMIT_EOF = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t              state, next_state;
  logic [IDX_W-1:0]    index, index_d;
  logic [31:0]         word, word_d;
  logic [7:0]          csum, csum_d;
  logic [CHAR_W-1:0]   cidx, cidx_d, cidx_inc;
  logic [31:0]         iaddr_d;
  logic [7:0]          tx_data_d;
  logic                override_d, iren_d, tx_valid_d, busy_d, done_d;

  logic [15:0]         rec_addr;
  logic [7:0]          csum_calc;
  logic [7:0]          rec_chars [SLOTS];
  logic [7:0]          eof_chars [SLOTS];
  logic                accept, last_word, rec_last, eof_last;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign accept    = bus.tx_valid & bus.tx_ready;
  assign cidx_inc  = cidx + CHAR_W'(1);
  assign rec_last  = (cidx == CHAR_W'(REC_LEN - 1));
  assign eof_last  = (cidx == CHAR_W'(EOF_LEN - 1));
  assign last_word = (index == IDX_W'(WORDS - 1));
  assign rec_addr  = 16'(ADDR_W'({index, 2'b00}));

  // Two's-complement checksum over count, address, type and data bytes
  always_comb begin
    csum_calc = 8'h00 - (8'h04 + rec_addr[15:8] + rec_addr[7:0] +
                         word[31:24] + word[23:16] + word[15:8] + word[7:0]);
  end

  // Character table for the current data record
  always_comb begin
    for (int i = 0; i < SLOTS; i++) rec_chars[i] = 8'h00;
    rec_chars[0]  = 8'h3A;
    rec_chars[1]  = 8'h30;
    rec_chars[2]  = 8'h34;
    rec_chars[3]  = hex_char(rec_addr[15:12]);
    rec_chars[4]  = hex_char(rec_addr[11:8]);
    rec_chars[5]  = hex_char(rec_addr[7:4]);
    rec_chars[6]  = hex_char(rec_addr[3:0]);
    rec_chars[7]  = 8'h30;
    rec_chars[8]  = 8'h30;
    rec_chars[9]  = hex_char(word[31:28]);
    rec_chars[10] = hex_char(word[27:24]);
    rec_chars[11] = hex_char(word[23:20]);
    rec_chars[12] = hex_char(word[19:16]);
    rec_chars[13] = hex_char(word[15:12]);
    rec_chars[14] = hex_char(word[11:8]);
    rec_chars[15] = hex_char(word[7:4]);
    rec_chars[16] = hex_char(word[3:0]);
    rec_chars[17] = hex_char(csum[7:4]);
    rec_chars[18] = hex_char(csum[3:0]);
`ifdef RAMDUMP_CRLF_EN
    rec_chars[19] = 8'h0D;
    rec_chars[20] = 8'h0A;
`else
    rec_chars[19] = 8'h0A;
`endif
  end

  // Character table for the fixed EOF record ":00000001FF"
  always_comb begin
    for (int i = 0; i < SLOTS; i++) eof_chars[i] = 8'h00;
    eof_chars[0] = 8'h3A;
    for (int i = 1; i < 8; i++) eof_chars[i] = 8'h30;
    eof_chars[8]  = 8'h31;
    eof_chars[9]  = 8'h46;
    eof_chars[10] = 8'h46;
`ifdef RAMDUMP_CRLF_EN
    eof_chars[11] = 8'h0D;
    eof_chars[12] = 8'h0A;
`else
    eof_chars[11] = 8'h0A;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (bus.start) next_state = S_REQ;
      S_REQ:      if (!bus.iwait) next_state = S_CHECK;
      S_CHECK:    next_state = (word == 32'h0) ? S_NEXT : S_EMIT_REC;
      S_EMIT_REC: if (accept && rec_last) next_state = S_NEXT;
      S_NEXT:     next_state = last_word ? S_EMIT_EOF : S_REQ;
      S_EMIT_EOF: if (accept && eof_last) next_state = S_DONE;
      S_DONE:     next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // Output and datapath next values; outputs follow next_state so they are registered
  always_comb begin
    index_d    = index;
    word_d     = word;
    csum_d     = csum;
    cidx_d     = cidx;
    tx_data_d  = bus.tx_data;
    tx_valid_d = bus.tx_valid;
    override_d = (next_state != S_IDLE) && (next_state != S_DONE);
    busy_d     = override_d;
    done_d     = (next_state == S_DONE);
    iren_d     = (next_state == S_REQ);
    case (state)
      S_IDLE: if (bus.start) index_d = '0;
      S_REQ:  if (!bus.iwait) word_d = bus.iload;
      S_CHECK: begin
        csum_d = csum_calc;
        if (word != 32'h0) begin
          cidx_d     = '0;
          tx_valid_d = 1'b1;
          tx_data_d  = 8'h3A;
        end
      end
      S_EMIT_REC: begin
        if (accept) begin
          if (rec_last) begin
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
          end else begin
            cidx_d    = cidx_inc;
            tx_data_d = rec_chars[cidx_inc];
          end
        end
      end
      S_NEXT: begin
        if (last_word) begin
          cidx_d     = '0;
          tx_valid_d = 1'b1;
          tx_data_d  = 8'h3A;
        end else begin
          index_d = index + IDX_W'(1);
        end
      end
      S_EMIT_EOF: begin
        if (accept) begin
          if (eof_last) begin
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
          end else begin
            cidx_d    = cidx_inc;
            tx_data_d = eof_chars[cidx_inc];
          end
        end
      end
      default: ;
    endcase
    iaddr_d = iren_d ? 32'({index_d, 2'b00}) : 32'h0;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      index             <= '0;
      word              <= '0;
      csum              <= '0;
      cidx              <= '0;
      bus.override_ctrl <= 1'b0;
      bus.iaddr         <= '0;
      bus.iren          <= 1'b0;
      bus.tx_data       <= '0;
      bus.tx_valid      <= 1'b0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
    end else begin
      index             <= index_d;
      word              <= word_d;
      csum              <= csum_d;
      cidx              <= cidx_d;
      bus.override_ctrl <= override_d;
      bus.iaddr         <= iaddr_d;
      bus.iren          <= iren_d;
      bus.tx_data       <= tx_data_d;
      bus.tx_valid      <= tx_valid_d;
      bus.busy          <= busy_d;
      bus.done          <= done_d;
    end
  end

endmodule

// File: tb/tb_ram_hex_dumper.sv
// Scoreboard bench: a small (4-word) and a full-size (16384-word) dumper.
module tb_ram_hex_dumper;
  localparam int unsigned WS = 4;
  localparam int unsigned WB = 16384;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_hex_dumper_if bus_s ();
  ram_hex_dumper_if bus_b ();

  ram_hex_dumper #(.WORDS(WS), .ADDR_W(16)) dut_s (.clk(clk), .rst(rst), .bus(bus_s));
  ram_hex_dumper #(.WORDS(WB), .ADDR_W(16)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  logic [31:0] mem_s [WS];
  logic [31:0] mem_b [WB];
  int unsigned wcnt = 0;
  bit          stall_rd = 1'b0;
  int          rdy_mode = 0;

  byte unsigned exp_s[$];
  byte unsigned exp_b[$];
  int unsigned  exp_rd[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           done_cnt[2];
  int           acc_s = 0;
  bit           pv[2];
  byte unsigned pd[2];
  bit           hv = 1'b0;
  logic [31:0]  ha;

  // RAM models: small one inserts 3 wait cycles per read when stall_rd is set
  assign bus_s.iload = mem_s[bus_s.iaddr[3:2]];
  assign bus_s.iwait = stall_rd && (wcnt < 3);
  assign bus_b.iload = mem_b[bus_b.iaddr[15:2]];
  assign bus_b.iwait = 1'b0;
  assign bus_b.tx_ready = 1'b1;

  always @(posedge clk) begin
    if (!bus_s.iren)      wcnt <= 0;
    else if (bus_s.iwait) wcnt <= wcnt + 1;
  end

  // Sink readiness for the small instance: always, toggling, or random
  initial begin
    bus_s.tx_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        1:       bus_s.tx_ready = ~bus_s.tx_ready;
        2:       bus_s.tx_ready = 1'($urandom_range(0, 1));
        default: bus_s.tx_ready = 1'b1;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_ch(input int sel, input byte unsigned c);
    if (sel == 0) exp_s.push_back(c);
    else          exp_b.push_back(c);
  endtask

  task automatic push_str(input int sel, input string s);
    for (int k = 0; k < s.len(); k++) push_ch(sel, s[k]);
  endtask

  task automatic push_eol(input int sel);
`ifdef RAMDUMP_CRLF_EN
    push_ch(sel, 8'h0D);
`endif
    push_ch(sel, 8'h0A);
  endtask

  task automatic push_eof(input int sel);
    push_str(sel, ":00000001FF");
    push_eol(sel);
  endtask

  task automatic push_hex(input int sel, input logic [31:0] v, input int digits);
    string hx = "0123456789ABCDEF";
    for (int k = digits - 1; k >= 0; k--) push_ch(sel, hx[(v >> (4 * k)) & 32'hF]);
  endtask

  // Reference dump of mem_s: one record per non-zero word, then EOF
  task automatic build_expected();
    logic [31:0] d;
    int unsigned a, s, cs;
    for (int i = 0; i < WS; i++) begin
      d = mem_s[i];
      if (d != 32'h0) begin
        a  = (i * 4) % 65536;
        s  = 4 + a / 256 + a % 256 + d[31:24] + d[23:16] + d[15:8] + d[7:0];
        cs = (256 - s % 256) % 256;
        push_ch(0, 8'h3A);
        push_hex(0, 4, 2);
        push_hex(0, a, 4);
        push_hex(0, 0, 2);
        push_hex(0, d, 8);
        push_hex(0, cs, 2);
        push_eol(0);
      end
    end
    push_eof(0);
  endtask

  task automatic mon_tx(input int sel, input logic v, input logic r, input logic [7:0] d);
    byte unsigned e;
    if (pv[sel]) begin
      check($sformatf("tx_valid_hold[%0d]", sel), 32'(v), 32'd1);
      check($sformatf("tx_data_stable[%0d]", sel), 32'(d), 32'(pd[sel]));
    end
    if (v && r) begin
      if ((sel == 0 && exp_s.size() == 0) || (sel == 1 && exp_b.size() == 0)) begin
        n_checks++;
        n_fail++;
        $display("FAIL tx_unexpected[%0d]: got 0x%0h, expected no character", sel, d);
      end else begin
        e = (sel == 0) ? exp_s.pop_front() : exp_b.pop_front();
        check($sformatf("tx_char[%0d]", sel), 32'(d), 32'(e));
      end
      if (sel == 0) acc_s++;
    end
    pv[sel] = v && !r;
    pd[sel] = d;
  endtask

  // Monitor: samples on the falling edge, pops scoreboards on every handshake
  initial begin
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        hv    = 1'b0;
      end else begin
        mon_tx(0, bus_s.tx_valid, bus_s.tx_ready, bus_s.tx_data);
        mon_tx(1, bus_b.tx_valid, bus_b.tx_ready, bus_b.tx_data);
        if (bus_s.tx_valid) check("no_read_while_emit", 32'(bus_s.iren), 32'd0);
        if (bus_s.iren) begin
          if (hv) check("iaddr_held_in_wait", bus_s.iaddr, ha);
          if (bus_s.iwait) begin
            hv = 1'b1;
            ha = bus_s.iaddr;
          end else begin
            hv = 1'b0;
            if (exp_rd.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL read_unexpected: got iaddr 0x%0h, expected no read", bus_s.iaddr);
            end else check("read_addr", bus_s.iaddr, exp_rd.pop_front());
          end
        end else hv = 1'b0;
        if (bus_s.done) begin
          done_cnt[0]++;
          check("done_releases_port_s", 32'(bus_s.override_ctrl), 32'd0);
        end
        if (bus_b.done) begin
          done_cnt[1]++;
          check("done_releases_port_b", 32'(bus_b.override_ctrl), 32'd0);
        end
      end
    end
  end

  // Synchronous reset from a non-edge time; checks the small dumper is quiet afterwards
  task automatic reset_now();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_tx_valid", 32'(bus_s.tx_valid), 32'd0);
    check("rst_override", 32'(bus_s.override_ctrl), 32'd0);
    check("rst_iren", 32'(bus_s.iren), 32'd0);
    check("rst_busy", 32'(bus_s.busy), 32'd0);
    exp_s.delete();
    exp_b.delete();
    exp_rd.delete();
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic wait_done(input int sel, input int base, input int budget, output bit ok);
    int n = 0;
    while (done_cnt[sel] == base && n < budget) begin
      @(posedge clk);
      n++;
    end
    ok = (done_cnt[sel] != base);
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout[%0d]: no done within %0d cycles", sel, budget);
    end
  endtask

  // One dump on the small instance; expected characters already queued by the caller
  task automatic run_small(input int mode, input bit stall, input bit extra_start);
    int base = done_cnt[0];
    bit ok;
    rdy_mode = mode;
    stall_rd = stall;
    for (int i = 0; i < WS; i++) exp_rd.push_back(i * 4);
    @(posedge clk); #2;
    bus_s.start = 1'b1;
    @(posedge clk); #2;
    bus_s.start = 1'b0;
    @(negedge clk);
    check("override_after_start", 32'(bus_s.override_ctrl), 32'd1);
    check("busy_after_start", 32'(bus_s.busy), 32'd1);
    if (extra_start) begin
      repeat (4) @(posedge clk);
      #2 bus_s.start = 1'b1;
      @(posedge clk); #2;
      bus_s.start = 1'b0;
    end
    wait_done(0, base, 3000, ok);
    if (!ok) reset_now();
    repeat (4) @(negedge clk);
    check("done_once", 32'(done_cnt[0] - base), 32'd1);
    check("stream_drained", 32'(exp_s.size()), 32'd0);
    check("reads_drained", 32'(exp_rd.size()), 32'd0);
    check("idle_busy", 32'(bus_s.busy), 32'd0);
    rdy_mode = 0;
    stall_rd = 1'b0;
  endtask

  initial begin
    bit ok;
    int n;
    int base;
    rst = 1'b1;
    bus_s.start = 1'b0;
    bus_b.start = 1'b0;
    for (int i = 0; i < WS; i++) mem_s[i] = 32'h0;
    for (int i = 0; i < WB; i++) mem_b[i] = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_override", 32'(bus_s.override_ctrl), 32'd0);
    check("reset_iren", 32'(bus_s.iren), 32'd0);
    check("reset_iaddr", bus_s.iaddr, 32'd0);
    check("reset_tx_valid", 32'(bus_s.tx_valid), 32'd0);
    check("reset_tx_data", 32'(bus_s.tx_data), 32'd0);
    check("reset_busy", 32'(bus_s.busy), 32'd0);
    check("reset_done", 32'(bus_s.done), 32'd0);
    check("reset_busy_b", 32'(bus_b.busy), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    // All-zero RAM: EOF only
    push_eof(0);
    run_small(0, 1'b0, 1'b0);

    // Word 0 = 0x13
    mem_s[0] = 32'h0000_0013;
    push_str(0, ":0400000000000013E9");
    push_eol(0);
    push_eof(0);
    run_small(0, 1'b0, 1'b0);

    // Word 3 = 0xDEADBEEF, unstalled then with backpressure and RAM wait
    mem_s[0] = 32'h0;
    mem_s[3] = 32'hDEAD_BEEF;
    for (int r = 0; r < 2; r++) begin
      push_str(0, ":04000C00DEADBEEFB8");
      push_eol(0);
      push_eof(0);
      run_small(r, 1'(r), 1'b0);
    end

    // Random contents, random sink and RAM behaviour, stray starts while busy
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < WS; i++)
        mem_s[i] = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
      build_expected();
      run_small($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'(t % 2));
    end

    // Reset after 7 characters of a record, then a clean dump
    mem_s[0] = $urandom | 32'h1;
    build_expected();
    acc_s = 0;
    for (int i = 0; i < WS; i++) exp_rd.push_back(i * 4);
    @(posedge clk); #2;
    bus_s.start = 1'b1;
    @(posedge clk); #2;
    bus_s.start = 1'b0;
    n = 0;
    while (acc_s < 7 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("chars_before_reset", 32'(acc_s), 32'd7);
    #1;
    base = done_cnt[0];
    reset_now();
    repeat (30) @(negedge clk);
    check("no_done_after_abort", 32'(done_cnt[0] - base), 32'd0);
    build_expected();
    run_small(1, 1'b1, 1'b0);

    // Full-size RAM: last word at byte address 0xFFFC
    mem_b[WB-1] = 32'h0000_0001;
    push_str(1, ":04FFFC000000000100");
    push_eol(1);
    push_eof(1);
    base = done_cnt[1];
    @(posedge clk); #2;
    bus_b.start = 1'b1;
    @(posedge clk); #2;
    bus_b.start = 1'b0;
    wait_done(1, base, 60000, ok);
    repeat (3) @(negedge clk);
    check("big_done_once", 32'(done_cnt[1] - base), 32'd1);
    check("big_stream_drained", 32'(exp_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
